// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the pc, issues one imem request at a time and
// buffers the returned word in a single output register for decode.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        decode_ready,
    output logic        fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        kill;
    logic        consume;
    logic        grant;

    // A new request is only issued once the buffer is guaranteed empty when the
    // response lands, so no skid storage is needed behind the output register.
    assign imem_req  = rst_n && (state == S_FETCH) && (!instr_valid || decode_ready);
    assign imem_addr = pc;
    assign consume   = instr_valid && decode_ready;
    assign grant     = imem_req && imem_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            kill        <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
            fault       <= 1'b0;
            fetch_count <= 32'h0;
        end else if (state != S_FAULT) begin
            if (redirect_valid) begin
                // The buffered word is wrong-path; it is flushed, never counted.
                instr_valid <= 1'b0;
                if (redirect_target[1:0] != 2'b00) begin
                    fault <= 1'b1;
                    kill  <= 1'b0;
                    state <= S_FAULT;
                end else begin
                    pc <= redirect_target;
                    if (state == S_FETCH) begin
                        if (grant) begin
                            kill  <= 1'b1;
                            state <= S_WAIT;
                        end
                    end else if (imem_rvalid) begin
                        kill  <= 1'b0;
                        state <= S_FETCH;
                    end else begin
                        kill <= 1'b1;
                    end
                end
            end else begin
                if (consume) begin
                    instr_valid <= 1'b0;
                    fetch_count <= fetch_count + 32'd1;
                end
                if (state == S_FETCH) begin
                    if (grant)
                        state <= S_WAIT;
                end else if (imem_rvalid) begin
                    if (!kill) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        pc          <= pc + 32'd4;
                    end
                    kill  <= 1'b0;
                    state <= S_FETCH;
                end
            end
        end
    end

endmodule
